// File: rtl/conv_mac_multi.sv
// conv_mac_multi: multi-channel KxK convolution multiply-accumulate.
// Fetches a KERNEL_SIZE x KERNEL_SIZE kernel into a local register file (or
// reuses the stored one), streams NUM_CH window channels in parallel, and
// returns one shifted, saturated DATA_WIDTH result per channel over a
// valid/ready handshake.
// Build option: define CONV_SIGNED_EN for two's-complement operands and
// signed saturation. When it is undefined, all operands are unsigned.
//
// state       | meaning
// IDLE        | waiting for i_start; address outputs parked at 0
// LOAD_KERNEL | kernel addresses 0..N-1, capture one cycle later (N+1 cycles)
// MAC         | window addresses 0..N-1, accumulate one cycle later (N+1 cycles)
// OUTPUT      | o_result held with o_valid until i_ready
module conv_mac_multi #(
    parameter int KERNEL_SIZE    = 3,
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_CH         = 2,
    parameter int WIN_ADDR_WIDTH = 4,
    parameter int KER_ADDR_WIDTH = 6,
    parameter int OUT_SHIFT      = 0
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_start,
    input  logic                           i_reload_kernel,
    output logic [KER_ADDR_WIDTH-1:0]      o_kernel_addr,
    input  logic [DATA_WIDTH-1:0]          i_kernel_data,
    output logic [WIN_ADDR_WIDTH-1:0]      o_window_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   i_window_data,
    output logic [NUM_CH*DATA_WIDTH-1:0]   o_result,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic                           o_busy,
    output logic                           o_done
);
    localparam int N     = KERNEL_SIZE * KERNEL_SIZE;
    localparam int PW    = 2 * DATA_WIDTH;
    localparam int ACC_W = PW + $clog2(N) + 1;
    localparam int CW    = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N);
    localparam logic [CW-1:0] CNT_PEN  = CW'(N - 1);

`ifdef CONV_SIGNED_EN
    localparam bit SGN       = 1'b1;
    localparam int SAT_MAX_I = 2 ** (DATA_WIDTH - 1) - 1;
    localparam int SAT_MIN_I = -(2 ** (DATA_WIDTH - 1));
`else
    localparam bit SGN       = 1'b0;
    localparam int SAT_MAX_I = 2 ** DATA_WIDTH - 1;
    localparam int SAT_MIN_I = 0;
`endif
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(SAT_MAX_I);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(SAT_MIN_I);

    typedef enum logic [1:0] {IDLE, LOAD_KERNEL, MAC, OUTPUT} state_t;

    state_t                     state, state_next;
    logic [CW-1:0]              cnt, cnt_next, tap;
    logic                       kernel_valid, kv_next;
    logic [KER_ADDR_WIDTH-1:0]  kaddr_next;
    logic [WIN_ADDR_WIDTH-1:0]  waddr_next;
    logic                       valid_next, done_next;
    logic                       cap_kernel, mac_step, acc_clear, res_load;

    logic [DATA_WIDTH-1:0]      kernel [N];
    logic signed [ACC_W-1:0]    acc [NUM_CH];
    logic signed [ACC_W-1:0]    acc_sum [NUM_CH];
    logic signed [ACC_W-1:0]    shifted [NUM_CH];
    logic signed [PW-1:0]       op_w [NUM_CH];
    logic signed [PW-1:0]       op_k;
    logic signed [PW-1:0]       prod [NUM_CH];
    logic [DATA_WIDTH-1:0]      sat [NUM_CH];

    // Capture and accumulate always refer to the address issued one cycle earlier.
    assign tap    = cnt - CW'(1);
    assign o_busy = (state != IDLE);

    // State and control register update.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            cnt           <= '0;
            kernel_valid  <= 1'b0;
            o_kernel_addr <= '0;
            o_window_addr <= '0;
            o_valid       <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            kernel_valid  <= kv_next;
            o_kernel_addr <= kaddr_next;
            o_window_addr <= waddr_next;
            o_valid       <= valid_next;
            o_done        <= done_next;
        end
    end

    // Next-state, address sequencing and datapath strobes.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        kv_next    = kernel_valid;
        kaddr_next = o_kernel_addr;
        waddr_next = o_window_addr;
        valid_next = o_valid;
        done_next  = 1'b0;
        cap_kernel = 1'b0;
        mac_step   = 1'b0;
        acc_clear  = 1'b0;
        res_load   = 1'b0;
        case (state)
            IDLE: begin
                kaddr_next = '0;
                waddr_next = '0;
                cnt_next   = '0;
                if (i_start) begin
                    if (i_reload_kernel || !kernel_valid) begin
                        state_next = LOAD_KERNEL;
                    end else begin
                        state_next = MAC;
                        acc_clear  = 1'b1;
                    end
                end
            end
            LOAD_KERNEL: begin
                cap_kernel = (cnt != '0);
                if (cnt == CNT_LAST) begin
                    state_next = MAC;
                    cnt_next   = '0;
                    kv_next    = 1'b1;
                    acc_clear  = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                    if (cnt < CNT_PEN)
                        kaddr_next = o_kernel_addr + KER_ADDR_WIDTH'(1);
                end
            end
            MAC: begin
                mac_step = (cnt != '0);
                if (cnt == CNT_LAST) begin
                    state_next = OUTPUT;
                    valid_next = 1'b1;
                    res_load   = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                    if (cnt < CNT_PEN)
                        waddr_next = o_window_addr + WIN_ADDR_WIDTH'(1);
                end
            end
            OUTPUT: begin
                if (i_ready) begin
                    valid_next = 1'b0;
                    done_next  = 1'b1;
                    kaddr_next = '0;
                    waddr_next = '0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Per-channel product, running sum, output shift and saturation.
    always_comb begin
        op_k = {{DATA_WIDTH{SGN & kernel[tap][DATA_WIDTH-1]}}, kernel[tap]};
        for (int c = 0; c < NUM_CH; c++) begin
            op_w[c] = {{DATA_WIDTH{SGN & i_window_data[c*DATA_WIDTH + DATA_WIDTH-1]}},
                       i_window_data[c*DATA_WIDTH +: DATA_WIDTH]};
            prod[c]    = op_w[c] * op_k;
            acc_sum[c] = acc[c] + {{(ACC_W-PW){SGN & prod[c][PW-1]}}, prod[c]};
            shifted[c] = acc_sum[c] >>> OUT_SHIFT;
            if (shifted[c] > SAT_MAX)
                sat[c] = SAT_MAX[DATA_WIDTH-1:0];
            else if (shifted[c] < SAT_MIN)
                sat[c] = SAT_MIN[DATA_WIDTH-1:0];
            else
                sat[c] = shifted[c][DATA_WIDTH-1:0];
        end
    end

    // Accumulators and the registered result; the last tap is folded in on the exit edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int c = 0; c < NUM_CH; c++)
                acc[c] <= '0;
            o_result <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (acc_clear)
                    acc[c] <= '0;
                else if (mac_step)
                    acc[c] <= acc_sum[c];
                if (res_load)
                    o_result[c*DATA_WIDTH +: DATA_WIDTH] <= sat[c];
            end
        end
    end

    // Kernel register file keeps its contents across reset.
    always_ff @(posedge i_clk) begin
        if (cap_kernel)
            kernel[tap] <= i_kernel_data;
    end
endmodule

// File: tb/tb_conv_mac_multi.sv
// tb_conv_mac_multi: directed scoreboard bench for conv_mac_multi.
// Two instances (OUT_SHIFT 0 and 4) run in lockstep against shared memory
// contents; the expected results are hand-computed per vector.
module tb_conv_mac_multi;
    localparam int N = 9;

    logic        clk = 1'b0;
    logic        rst, start, reload, ready;
    logic [5:0]  kaddr0, kaddr1;
    logic [3:0]  waddr0, waddr1;
    logic [7:0]  kdata0, kdata1;
    logic [15:0] wdata0, wdata1;
    logic [15:0] res0, res1;
    logic        valid0, valid1, busy0, busy1, done0, done1;

    logic [7:0]  kmem [64];
    logic [7:0]  wm0  [16];
    logic [7:0]  wm1  [16];

    typedef struct {
        bit         reload;
        bit         load;
        bit         kr;
        logic [7:0] kv;
        bit         w0r;
        logic [7:0] w0v;
        bit         w1r;
        logic [7:0] w1v;
        logic [7:0] e0, e1, s0, s1;
    } vec_t;

    typedef struct {
        logic [7:0] e0, e1, s0, s1;
    } exp_t;

    vec_t vt [5];
    exp_t q [$];
    int   checks = 0;
    int   fails  = 0;
    logic done_prev = 1'b0;

    always #5 clk = ~clk;

    conv_mac_multi #(.OUT_SHIFT(0)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_reload_kernel(reload),
        .o_kernel_addr(kaddr0), .i_kernel_data(kdata0),
        .o_window_addr(waddr0), .i_window_data(wdata0),
        .o_result(res0), .o_valid(valid0), .i_ready(ready),
        .o_busy(busy0), .o_done(done0)
    );

    conv_mac_multi #(.OUT_SHIFT(4)) dut_s (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_reload_kernel(reload),
        .o_kernel_addr(kaddr1), .i_kernel_data(kdata1),
        .o_window_addr(waddr1), .i_window_data(wdata1),
        .o_result(res1), .o_valid(valid1), .i_ready(ready),
        .o_busy(busy1), .o_done(done1)
    );

    // One-cycle-latency memory models.
    always @(posedge clk) begin
        kdata0 <= kmem[kaddr0];
        kdata1 <= kmem[kaddr1];
        wdata0 <= {wm1[waddr0], wm0[waddr0]};
        wdata1 <= {wm1[waddr1], wm0[waddr1]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic init_table();
`ifdef CONV_SIGNED_EN
        vt[0] = '{1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 8'd100, 1'b0, 8'hFE, 8'h80, 8'h12, 8'hC7, 8'h01};
        vt[1] = '{1'b0, 1'b0, 1'b0, 8'd7,  1'b0, 8'h80,  1'b1, 8'h00, 8'h7F, 8'hD3, 8'h48, 8'hFD};
        vt[2] = '{1'b1, 1'b1, 1'b0, 8'd1,  1'b0, 8'hFE,  1'b1, 8'h00, 8'hEE, 8'h2D, 8'hFE, 8'h02};
        vt[3] = '{1'b0, 1'b1, 1'b1, 8'd0,  1'b1, 8'h00,  1'b0, 8'hFE, 8'h7F, 8'hA6, 8'h11, 8'hFA};
        vt[4] = '{1'b0, 1'b0, 1'b0, 8'd7,  1'b0, 8'h01,  1'b0, 8'hFD, 8'h2D, 8'h80, 8'h02, 8'hF7};
`else
        vt[0] = '{1'b1, 1'b1, 1'b0, 8'd1, 1'b1, 8'd0,   1'b0, 8'd10, 8'd45,  8'd90,  8'd2,   8'd5};
        vt[1] = '{1'b0, 1'b0, 1'b0, 8'd7, 1'b0, 8'd255, 1'b1, 8'd0,  8'd255, 8'd45,  8'd143, 8'd2};
        vt[2] = '{1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 8'd16,  1'b0, 8'd0,  8'd255, 8'd0,   8'd45,  8'd0};
        vt[3] = '{1'b0, 1'b1, 1'b1, 8'd0, 1'b1, 8'd0,   1'b0, 8'd2,  8'd255, 8'd90,  8'd17,  8'd5};
        vt[4] = '{1'b0, 1'b0, 1'b0, 8'd7, 1'b0, 8'd1,   1'b0, 8'd3,  8'd45,  8'd135, 8'd2,   8'd8};
`endif
    endtask

    task automatic load_mem(input int t);
        for (int i = 0; i < N; i++) begin
            kmem[i] = vt[t].kr  ? 8'(i + 1) : vt[t].kv;
            wm0[i]  = vt[t].w0r ? 8'(i + 1) : vt[t].w0v;
            wm1[i]  = vt[t].w1r ? 8'(i + 1) : vt[t].w1v;
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {3'b000, kaddr0, waddr0, res0, valid0, busy0, done0}, 32'd0);
        check({name, "_s"}, {3'b000, kaddr1, waddr1, res1, valid1, busy1, done1}, 32'd0);
    endtask

    // Issue one start at the current negedge; returns at the negedge where o_done is seen.
    task automatic run(input int t, input bit hold);
        exp_t e;
        int   lat  = 0;
        bit   kact = 1'b0;
        bit   d    = 1'b0;
        e.e0 = vt[t].e0; e.e1 = vt[t].e1; e.s0 = vt[t].s0; e.s1 = vt[t].s1;
        q.push_back(e);
        load_mem(t);
        start  = 1'b1;
        reload = vt[t].reload;
        ready  = !hold;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (kaddr0 != 6'd0) kact = 1'b1;
            if (valid0) lat = c;
        end
        check($sformatf("latency_t%0d", t), lat, vt[t].load ? 21 : 11);
        check($sformatf("kernel_fetch_t%0d", t), {31'd0, kact}, {31'd0, vt[t].load});
        check($sformatf("busy_t%0d", t), {31'd0, busy0}, 32'd1);
        if (hold) begin
            for (int c = 0; c < 5; c++) begin
                @(posedge clk);
                @(negedge clk);
                check($sformatf("hold_valid_c%0d", c), {31'd0, valid0}, 32'd1);
                check($sformatf("hold_result_c%0d", c), {16'd0, res0}, {16'd0, e.e1, e.e0});
            end
            ready = 1'b1;
        end
        for (int c = 0; c < 10 && !d; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done0) d = 1'b1;
        end
        check($sformatf("done_seen_t%0d", t), {31'd0, d}, 32'd1);
        check($sformatf("valid_dropped_t%0d", t), {31'd0, valid0}, 32'd0);
    endtask

    // Scoreboard monitor: compares on every cycle that will complete a handshake.
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (!rst) begin
            if (valid0 && ready) begin
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_valid: got result 0x%0h, expected no output", res0);
                end else begin
                    e = q.pop_front();
                    check("ch0", {24'd0, res0[7:0]}, {24'd0, e.e0});
                    check("ch1", {24'd0, res0[15:8]}, {24'd0, e.e1});
                    check("ch0_shift4", {24'd0, res1[7:0]}, {24'd0, e.s0});
                    check("ch1_shift4", {24'd0, res1[15:8]}, {24'd0, e.s1});
                    check("valid_shift4", {31'd0, valid1}, 32'd1);
                end
            end
            if (done0) check("done_one_cycle", {31'd0, done_prev}, 32'd0);
            done_prev = done0;
        end else begin
            done_prev = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found = 1'b0;
        rst = 1'b1; start = 1'b0; reload = 1'b0; ready = 1'b1;
        for (int i = 0; i < 64; i++) kmem[i] = 8'd0;
        for (int i = 0; i < 16; i++) begin
            wm0[i] = 8'd0;
            wm1[i] = 8'd0;
        end
        init_table();
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset_state");
        rst = 1'b0;
        @(negedge clk);

        run(0, 1'b0);
        run(1, 1'b1);
        run(2, 1'b0);

        // Aborted reuse run: reset at tap 4 of MAC, back-to-back with the previous done.
        load_mem(3);
        start  = 1'b1;
        reload = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (waddr0 == 4'd4) found = 1'b1;
        end
        check("reached_tap4", {31'd0, found}, 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_mac_reset");
        @(negedge clk);
        rst = 1'b0;

        run(3, 1'b0);
        run(4, 1'b0);

        repeat (3) @(negedge clk);
        check("queue_empty", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
